// File: rtl/dcache_tag_ctrl.sv
`default_nettype none

`ifndef TAG_XLEN
`define TAG_XLEN 20
`endif

// ============================================================================
// Package : dcache_tag_pkg
// Purpose : Tag memory write-word layout shared by the tag controller and
//           the tag FIFO it drives.
// Rev     : 1.0  initial release
// ============================================================================
package dcache_tag_pkg;
  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [`TAG_XLEN-1:0] tag;
  } type_cache_tag_mem_s;
endpackage

// ============================================================================
// Module  : dcache_tag_ctrl
// Purpose : Data-cache tag controller. Accepts one lookup at a time, compares
//           the captured tag against the tag FIFO, marks clean lines dirty on
//           store hits, and on a miss writes back a dirty victim (only when
//           the FIFO is full) before refilling the line at the FIFO write
//           pointer. Every request ends with a one-cycle resp_valid pulse.
// Rev     : 1.0  initial release
//
// Ports
//   clk, reset_n                     clock / async active-low reset
//   req_valid, req_ready             request handshake (IDLE only)
//   req_we, req_tag                  store flag and tag of the access
//   resp_valid, resp_hit, resp_index completion pulse, hit flag, entry index
//   tag_cmp_data                     captured tag presented to the FIFO
//   tag_hit, tag_hindex, tag_hdirty  FIFO compare results
//   tag_ctag, tag_cdirty, tag_wptr,  victim entry (at write pointer) and
//   tag_full                         FIFO fill state
//   tag_wr, tag_uwr, tag_uptr,       allocate-write / update-in-place write,
//   tag_wdata                        update index, write word
//   wb_req, wb_tag, wb_index, wb_ack         victim writeback handshake
//   fill_req, fill_tag, fill_index, fill_ack line refill handshake
// ============================================================================
module dcache_tag_ctrl #(
  parameter  int DP = 4,
  parameter  int TW = `TAG_XLEN,
  localparam int AW = $clog2(DP)
) (
  input  logic                              clk,
  input  logic                              reset_n,

  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic                              req_we,
  input  logic [TW-1:0]                     req_tag,

  output logic                              resp_valid,
  output logic                              resp_hit,
  output logic [AW-1:0]                     resp_index,

  output logic [TW-1:0]                     tag_cmp_data,
  input  logic [DP-1:0]                     tag_hit,
  input  logic [AW-1:0]                     tag_hindex,
  input  logic                              tag_hdirty,

  input  logic [TW-1:0]                     tag_ctag,
  input  logic                              tag_cdirty,
  input  logic [AW-1:0]                     tag_wptr,
  input  logic                              tag_full,

  output logic                              tag_wr,
  output logic                              tag_uwr,
  output logic [AW-1:0]                     tag_uptr,
  output dcache_tag_pkg::type_cache_tag_mem_s tag_wdata,

  output logic                              wb_req,
  output logic [TW-1:0]                     wb_tag,
  output logic [AW-1:0]                     wb_index,
  input  logic                              wb_ack,

  output logic                              fill_req,
  output logic [TW-1:0]                     fill_tag,
  output logic [AW-1:0]                     fill_index,
  input  logic                              fill_ack
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_UPD    = 3'd2,
    S_WB     = 3'd3,
    S_FILL   = 3'd4,
    S_RESP   = 3'd5
  } state_t;

  state_t                              r_state;
  logic                                r_req_ready;
  logic [TW-1:0]                       r_ctag;
  logic                                r_cwe;
  logic                                r_hit;
  logic [AW-1:0]                       r_hidx;
  logic                                r_resp_valid;
  logic                                r_resp_hit;
  logic [AW-1:0]                       r_resp_index;
  logic                                r_tag_uwr;
  dcache_tag_pkg::type_cache_tag_mem_s r_tag_wdata;
  logic                                r_wb_req;
  logic [TW-1:0]                       r_wb_tag;
  logic [AW-1:0]                       r_wb_index;
  logic                                r_fill_req;
  logic [AW-1:0]                       r_fill_index;

  logic                                w_hit;
  logic [`TAG_XLEN-1:0]                w_ctag_mem;

  // Several hit bits may be set; the FIFO-supplied index is trusted as is.
  assign w_hit      = |tag_hit;
  assign w_ctag_mem = r_ctag;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b1;
      r_ctag       <= '0;
      r_cwe        <= 1'b0;
      r_hit        <= 1'b0;
      r_hidx       <= '0;
      r_resp_valid <= 1'b0;
      r_resp_hit   <= 1'b0;
      r_resp_index <= '0;
      r_tag_uwr    <= 1'b0;
      r_tag_wdata  <= '0;
      r_wb_req     <= 1'b0;
      r_wb_tag     <= '0;
      r_wb_index   <= '0;
      r_fill_req   <= 1'b0;
      r_fill_index <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_ctag      <= req_tag;
            r_cwe       <= req_we;
            r_req_ready <= 1'b0;
            r_state     <= S_LOOKUP;
          end
        end

        S_LOOKUP: begin
          r_hit <= w_hit;
          if (w_hit) begin
            r_hidx <= tag_hindex;
            // Only a store to a clean line needs the dirty bit set.
            if (r_cwe && !tag_hdirty) begin
              r_tag_uwr   <= 1'b1;
              r_tag_wdata <= '{valid: 1'b1, dirty: 1'b1, tag: w_ctag_mem};
              r_state     <= S_UPD;
            end else begin
              r_state <= S_RESP;
            end
          end else begin
            // Allocate word is prepared now so it is stable for the whole
            // refill wait; tag_wr then fires combinationally with fill_ack.
            r_tag_wdata <= '{valid: 1'b1, dirty: r_cwe, tag: w_ctag_mem};
            // A dirty victim exists only once the FIFO has wrapped.
            if (tag_full && tag_cdirty) begin
              r_wb_req   <= 1'b1;
              r_wb_tag   <= tag_ctag;
              r_wb_index <= tag_wptr;
              r_state    <= S_WB;
            end else begin
              r_fill_req   <= 1'b1;
              r_fill_index <= tag_wptr;
              r_state      <= S_FILL;
            end
          end
        end

        S_UPD: begin
          r_tag_uwr <= 1'b0;
          r_state   <= S_RESP;
        end

        S_WB: begin
          if (wb_ack) begin
            r_wb_req     <= 1'b0;
            r_fill_req   <= 1'b1;
            r_fill_index <= tag_wptr;
            r_state      <= S_FILL;
          end
        end

        S_FILL: begin
          if (fill_ack) begin
            r_fill_req <= 1'b0;
            r_hidx     <= r_fill_index;
            r_state    <= S_RESP;
          end
        end

        S_RESP: begin
          r_resp_valid <= 1'b1;
          r_resp_hit   <= r_hit;
          r_resp_index <= r_hidx;
          r_req_ready  <= 1'b1;
          r_state      <= S_IDLE;
        end

        default: begin
          r_req_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready    = r_req_ready;
  assign resp_valid   = r_resp_valid;
  assign resp_hit     = r_resp_hit;
  assign resp_index   = r_resp_index;
  assign tag_cmp_data = r_ctag;
  // Allocate write lands in the ack cycle itself; reset drops it at once.
  assign tag_wr       = (r_state == S_FILL) && fill_ack;
  assign tag_uwr      = r_tag_uwr;
  assign tag_uptr     = r_hidx;
  assign tag_wdata    = r_tag_wdata;
  assign wb_req       = r_wb_req;
  assign wb_tag       = r_wb_tag;
  assign wb_index     = r_wb_index;
  assign fill_req     = r_fill_req;
  assign fill_tag     = r_ctag;
  assign fill_index   = r_fill_index;

endmodule

`default_nettype wire

// File: tb/tb_dcache_tag_ctrl.sv
`timescale 1ns/1ps
`default_nettype none

`ifndef TAG_XLEN
`define TAG_XLEN 20
`endif

// ============================================================================
// Module  : tb_dcache_tag_ctrl
// Purpose : Directed, table-driven bench for dcache_tag_ctrl. Each vector
//           sets up the tag-FIFO view and handshake wait times, issues one
//           request and checks latency, response and all side effects.
// Rev     : 1.0  initial release
// ============================================================================
module tb_dcache_tag_ctrl;
  import dcache_tag_pkg::*;

  localparam int DP = 4;
  localparam int AW = 2;
  localparam int TW = `TAG_XLEN;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [TW-1:0] req_tag = '0;
  logic          resp_valid, resp_hit;
  logic [AW-1:0] resp_index;
  logic [TW-1:0] tag_cmp_data;
  logic [DP-1:0] tag_hit = '0;
  logic [AW-1:0] tag_hindex = '0;
  logic          tag_hdirty = 1'b0;
  logic [TW-1:0] tag_ctag = '0;
  logic          tag_cdirty = 1'b0;
  logic [AW-1:0] tag_wptr = '0;
  logic          tag_full = 1'b0;
  logic          tag_wr, tag_uwr;
  logic [AW-1:0] tag_uptr;
  type_cache_tag_mem_s tag_wdata;
  logic          wb_req;
  logic [TW-1:0] wb_tag;
  logic [AW-1:0] wb_index;
  logic          wb_ack = 1'b0;
  logic          fill_req;
  logic [TW-1:0] fill_tag;
  logic [AW-1:0] fill_index;
  logic          fill_ack = 1'b0;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  dcache_tag_ctrl #(.DP(DP), .TW(TW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_index(resp_index),
    .tag_cmp_data(tag_cmp_data), .tag_hit(tag_hit), .tag_hindex(tag_hindex),
    .tag_hdirty(tag_hdirty), .tag_ctag(tag_ctag), .tag_cdirty(tag_cdirty),
    .tag_wptr(tag_wptr), .tag_full(tag_full),
    .tag_wr(tag_wr), .tag_uwr(tag_uwr), .tag_uptr(tag_uptr), .tag_wdata(tag_wdata),
    .wb_req(wb_req), .wb_tag(wb_tag), .wb_index(wb_index), .wb_ack(wb_ack),
    .fill_req(fill_req), .fill_tag(fill_tag), .fill_index(fill_index), .fill_ack(fill_ack)
  );

  typedef struct {
    logic          we;
    logic [TW-1:0] tag;
    logic [DP-1:0] hit;
    logic [AW-1:0] hidx;
    logic          hdirty;
    logic          full;
    logic          cdirty;
    logic [TW-1:0] ctag;
    logic [AW-1:0] wptr;
    int            wbw;      // cycles of wb_req before wb_ack
    int            fw;       // cycles of fill_req before fill_ack
    logic          e_hit;
    logic [AW-1:0] e_idx;
    int            e_lat;    // edges from accept to resp_valid
    int            e_uwr;
    int            e_wr;
    int            e_wb;
    int            e_fill;
    logic          e_dirty;  // dirty bit of the expected write word
  } vec_t;

  function automatic vec_t mk(
    input logic we, input logic [TW-1:0] tag, input logic [DP-1:0] hit,
    input logic [AW-1:0] hidx, input logic hdirty, input logic full,
    input logic cdirty, input logic [TW-1:0] ctag, input logic [AW-1:0] wptr,
    input int wbw, input int fw, input logic e_hit, input logic [AW-1:0] e_idx,
    input int e_lat, input int e_uwr, input int e_wr, input int e_wb,
    input int e_fill, input logic e_dirty);
    vec_t v;
    v.we = we; v.tag = tag; v.hit = hit; v.hidx = hidx; v.hdirty = hdirty;
    v.full = full; v.cdirty = cdirty; v.ctag = ctag; v.wptr = wptr;
    v.wbw = wbw; v.fw = fw; v.e_hit = e_hit; v.e_idx = e_idx; v.e_lat = e_lat;
    v.e_uwr = e_uwr; v.e_wr = e_wr; v.e_wb = e_wb; v.e_fill = e_fill;
    v.e_dirty = e_dirty;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int lat = -1, uwr_n = 0, wr_n = 0, wb_n = 0, fill_n = 0, wbc = 0, fc = 0;
    logic r_hit_s = 1'b0;
    logic [AW-1:0] r_idx_s = '0;
    bit busy_ok = 1, wb_ok = 1, fill_ok = 1, upd_ok = 1, wd_ok = 1, coll = 0;
    bit prev_wb = 0, prev_fill = 0;
    logic [TW+1:0] wd;
    @(negedge clk);
    tag_hit = v.hit; tag_hindex = v.hidx; tag_hdirty = v.hdirty;
    tag_full = v.full; tag_cdirty = v.cdirty; tag_ctag = v.ctag; tag_wptr = v.wptr;
    req_tag = v.tag; req_we = v.we;
    chk({nm, ":ready_before"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (resp_valid) begin
        lat = k - 1; r_hit_s = resp_hit; r_idx_s = resp_index;
        break;
      end
      if (req_ready) busy_ok = 0;
      if (tag_uwr) begin
        uwr_n++;
        wd = tag_wdata;
        if (tag_uptr !== v.e_idx || wd !== {1'b1, 1'b1, v.tag}) upd_ok = 0;
      end
      if (wb_req) begin
        if (!prev_wb) wb_n++;
        if (wb_tag !== v.ctag || wb_index !== v.wptr) wb_ok = 0;
        wb_ack = (wbc == v.wbw); wbc++;
      end else wb_ack = 1'b0;
      prev_wb = wb_req;
      if (fill_req) begin
        if (!prev_fill) fill_n++;
        if (fill_tag !== v.tag || fill_index !== v.wptr) fill_ok = 0;
        fill_ack = (fc == v.fw); fc++;
      end else fill_ack = 1'b0;
      prev_fill = fill_req;
      #1;
      if (tag_wr) begin
        wr_n++;
        wd = tag_wdata;
        if (wd !== {1'b1, v.e_dirty, v.tag}) wd_ok = 0;
        if (tag_uwr) coll = 1;
      end
    end
    wb_ack = 1'b0; fill_ack = 1'b0;
    chk({nm, ":latency"}, 64'(lat), 64'(v.e_lat));
    chk({nm, ":resp_hit"}, 64'(r_hit_s), 64'(v.e_hit));
    chk({nm, ":resp_index"}, 64'(r_idx_s), 64'(v.e_idx));
    chk({nm, ":busy_ready_low"}, 64'(busy_ok), 64'd1);
    chk({nm, ":uwr_count"}, 64'(uwr_n), 64'(v.e_uwr));
    chk({nm, ":wr_count"}, 64'(wr_n), 64'(v.e_wr));
    chk({nm, ":wb_count"}, 64'(wb_n), 64'(v.e_wb));
    chk({nm, ":fill_count"}, 64'(fill_n), 64'(v.e_fill));
    chk({nm, ":wr_uwr_overlap"}, 64'(coll), 64'd0);
    if (v.e_uwr != 0) chk({nm, ":uptr_wdata"}, 64'(upd_ok), 64'd1);
    if (v.e_wr != 0)  chk({nm, ":wr_wdata"}, 64'(wd_ok), 64'd1);
    if (v.e_wb != 0)  chk({nm, ":wb_tag_index"}, 64'(wb_ok), 64'd1);
    if (v.e_fill != 0) chk({nm, ":fill_tag_index"}, 64'(fill_ok), 64'd1);
    @(negedge clk);
    chk({nm, ":resp_one_cycle"}, 64'(resp_valid), 64'd0);
  endtask

  vec_t vecs[9];

  initial begin
    bit seen, wr_seen, resp_seen;
    logic [TW+1:0] wd0;

    //      we tag      hit      hidx hd full cd ctag      wptr wbw fw hit idx lat uwr wr wb fill dirty
    vecs[0] = mk(0, 'h123,   4'b0000, 0, 0, 0, 0, 'h0,     0,   0,  3, 0, 0, 6, 0, 1, 0, 1, 0);
    vecs[1] = mk(1, 'h123,   4'b0100, 2, 0, 0, 0, 'h0,     0,   0,  0, 1, 2, 3, 1, 0, 0, 0, 1);
    vecs[2] = mk(0, 'h77,    4'b0000, 0, 0, 1, 1, 'h55,    1,   1,  2, 0, 1, 7, 0, 1, 1, 1, 0);
    vecs[3] = mk(1, 'hABC,   4'b0000, 0, 0, 1, 0, 'h99,    3,   0,  0, 0, 3, 3, 0, 1, 0, 1, 1);
    vecs[4] = mk(0, 'h456,   4'b0010, 1, 1, 0, 0, 'h0,     0,   0,  0, 1, 1, 2, 0, 0, 0, 0, 0);
    vecs[5] = mk(1, 'h456,   4'b1000, 3, 1, 1, 1, 'h11,    2,   0,  0, 1, 3, 2, 0, 0, 0, 0, 0);
    vecs[6] = mk(1, 'h3FF,   4'b0000, 0, 0, 0, 1, 'h22,    2,   0,  1, 0, 2, 4, 0, 1, 0, 1, 1);
    vecs[7] = mk(0, 'h789,   4'b1010, 3, 0, 0, 0, 'h0,     0,   0,  0, 1, 3, 2, 0, 0, 0, 0, 0);
    vecs[8] = mk(0, 'h1,     4'b0000, 0, 0, 1, 1, 'hFFFFF, 0,   0,  0, 0, 0, 4, 0, 1, 1, 1, 0);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    wd0 = tag_wdata;
    chk("reset:req_ready", 64'(req_ready), 64'd1);
    chk("reset:strobes", 64'({resp_valid, resp_hit, tag_wr, tag_uwr, wb_req, fill_req}), 64'd0);
    chk("reset:indices", 64'({resp_index, tag_uptr, wb_index, fill_index}), 64'd0);
    chk("reset:tags", 64'({tag_cmp_data, wb_tag, fill_tag}), 64'd0);
    chk("reset:wdata", 64'(wd0), 64'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    chk("cmp_data_held", 64'(tag_cmp_data), 64'('h1));

    // Stray acknowledges while idle must be ignored
    @(negedge clk);
    wb_ack = 1'b1; fill_ack = 1'b1;
    seen = 0;
    repeat (3) begin
      @(negedge clk); #1;
      if (tag_wr || wb_req || fill_req || resp_valid || !req_ready) seen = 1;
    end
    wb_ack = 1'b0; fill_ack = 1'b0;
    chk("stray_ack_ignored", 64'(seen), 64'd0);

    // Reset pulsed while a refill is outstanding
    @(negedge clk);
    tag_hit = '0; tag_full = 1'b0; tag_cdirty = 1'b0; tag_wptr = 2'd1;
    req_tag = 'h5A5; req_we = 1'b0; req_valid = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (fill_req) begin seen = 1; break; end
    end
    chk("abort:fill_req_seen", 64'(seen), 64'd1);
    reset_n = 1'b0; fill_ack = 1'b1;
    #1;
    chk("abort:fill_req_dropped", 64'(fill_req), 64'd0);
    chk("abort:no_tag_wr", 64'(tag_wr), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    wr_seen = 0; resp_seen = 0;
    repeat (5) begin
      @(negedge clk); #1;
      if (tag_wr) wr_seen = 1;
      if (resp_valid) resp_seen = 1;
    end
    fill_ack = 1'b0;
    chk("abort:ready_after", 64'(req_ready), 64'd1);
    chk("abort:no_wr_after", 64'(wr_seen), 64'd0);
    chk("abort:no_resp_after", 64'(resp_seen), 64'd0);

    // Normal operation resumes after the abort
    run_vec(vecs[4], "post_abort");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
